// File: rtl/bk_pipe_adder.sv
// Pipelined Brent-Kung adder/subtractor with a ripple-carry shadow checker and mismatch counter.
// Latency PIPE+2 cycles from accepted beat to out_valid; one beat per cycle when not stalled.
// Backpressure: out_valid & ~out_ready freezes every stage, bubbles included; in_ready = ~stall.
module bk_pipe_adder #(
  parameter int W    = 32,
  parameter int PIPE = 1,
  parameter int ECW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   ina,
  input  logic [W-1:0]   inb,
  input  logic           cin,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   sum,
  output logic           cout,
  output logic           ovf,
  output logic           chk_err,
  output logic [ECW-1:0] err_cnt,
  input  logic           err_clr
);

  // Prefix tree shape: L up-sweep levels followed by L-1 down-sweep levels.
  localparam int L  = $clog2(W);
  localparam int NL = 2 * L - 1;

  // Operands after conditioning (B' and c0), held in the input register.
  typedef struct packed {
    logic         vld;
    logic         c0;
    logic [W-1:0] a;
    logic [W-1:0] bp;
  } opnd_t;

  // Everything one tree level needs: the beat's valid, the shadow operands,
  // the bitwise propagate for the final sum, and the running group G/P.
  typedef struct packed {
    logic         vld;
    logic         c0;
    logic [W-1:0] a;
    logic [W-1:0] bp;
    logic [W-1:0] pr;
    logic [W-1:0] g;
    logic [W-1:0] gp;
  } lane_t;

  // Pipeline stage that prefix level k belongs to. Stage index grows by at
  // most one per level, so each change marks one register boundary; the
  // floor division spreads the PIPE boundaries evenly over the NL levels.
  function automatic int stage_of(input int k);
    return (k * (PIPE + 1)) / NL;
  endfunction

  // Distance to the combining partner at level k.
  function automatic int lvl_span(input int k);
    if (k < L) return 1 << k;
    return 1 << (2 * L - 2 - k);
  endfunction

  // Whether bit i gets a black cell at level k.
  // Up-sweep: bits whose index+1 is a multiple of 2*span.
  // Down-sweep: the odd multiples of span above the first complete block.
  function automatic bit lvl_act(input int k, input int i);
    int s;
    s = lvl_span(k);
    if (k < L) return ((i + 1) % (2 * s)) == 0;
    return (((i + 1) % (2 * s)) == s) && ((i + 1) >= 3 * s);
  endfunction

  function automatic logic [W-1:0] act_mask(input int k);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) m[i] = lvl_act(k, i);
    return m;
  endfunction

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  opnd_t in_q;

  // Input register: condition B and the carry-in so the tree only ever adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
    end else if (!stall) begin
      in_q.vld <= in_valid;
      in_q.a   <= ina;
      in_q.bp  <= sub ? ~inb : inb;
      in_q.c0  <= sub | cin;
    end
  end

  lane_t seed;

  // Bitwise generate/propagate; the carry-in acts as a generate at bit -1,
  // folded into bit 0 so group generate G[i] directly equals carry c[i+1].
  always_comb begin
    seed.vld  = in_q.vld;
    seed.c0   = in_q.c0;
    seed.a    = in_q.a;
    seed.bp   = in_q.bp;
    seed.pr   = in_q.a ^ in_q.bp;
    seed.g    = in_q.a & in_q.bp;
    seed.g[0] = seed.g[0] | (seed.pr[0] & in_q.c0);
    seed.gp   = seed.pr;
  end

  for (genvar k = 0; k < NL; k++) begin : g_lvl
    localparam int           SPAN = lvl_span(k);
    localparam logic [W-1:0] M    = act_mask(k);

    lane_t        li;
    lane_t        lo;
    logic [W-1:0] g_sh;
    logic [W-1:0] gp_sh;

    if (k == 0) begin : g_seed
      assign li = seed;
    end else if (stage_of(k) != stage_of(k - 1)) begin : g_reg
      // Internal pipeline register between two prefix levels.
      always_ff @(posedge clk) begin
        if (rst) begin
          li <= '0;
        end else if (!stall) begin
          li <= g_lvl[k-1].lo;
        end
      end
    end else begin : g_wire
      assign li = g_lvl[k-1].lo;
    end

    // Partner values shifted into place so every cell is a plain vector op.
    assign g_sh  = li.g  << SPAN;
    assign gp_sh = li.gp << SPAN;

    // Black cells on the active bits of this level; other bits pass through.
    always_comb begin
      lo    = li;
      lo.g  = (li.g  & ~M) | (M & (li.g | (li.gp & g_sh)));
      lo.gp = (li.gp & ~M) | (M & li.gp & gp_sh);
    end
  end

  lane_t last;
  assign last = g_lvl[NL-1].lo;

  logic         unused_gp;
  assign unused_gp = ^last.gp;

  // Carries from the tree: c[0] = c0, c[i+1] = G[0..i].
  logic [W:0]   bk_c;
  logic [W-1:0] bk_sum;
  logic         bk_cout;
  logic         bk_ovf;

  assign bk_c    = {last.g, last.c0};
  assign bk_sum  = last.pr ^ bk_c[W-1:0];
  assign bk_cout = bk_c[W];
  assign bk_ovf  = bk_c[W-1] ^ bk_cout;

  logic [W-1:0] rc_sum;
  logic         rc_cout;

  // Shadow ripple-carry adder on the same conditioned operands as the tree.
  always_comb begin
    logic c;
    c      = last.c0;
    rc_sum = '0;
    for (int i = 0; i < W; i++) begin
      rc_sum[i] = last.a[i] ^ last.bp[i] ^ c;
      c         = (last.a[i] & last.bp[i]) | ((last.a[i] ^ last.bp[i]) & c);
    end
    rc_cout = c;
  end

  logic mis;
  assign mis = {bk_cout, bk_sum} != {rc_cout, rc_sum};

  // Output register: bubbles clear out_valid but leave the last data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      chk_err   <= 1'b0;
    end else if (!stall) begin
      out_valid <= last.vld;
      if (last.vld) begin
        sum     <= bk_sum;
        cout    <= bk_cout;
        ovf     <= bk_ovf;
        chk_err <= mis;
      end
    end
  end

  // Saturating count of delivered beats that failed the shadow check; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && chk_err && (err_cnt != {ECW{1'b1}})) begin
      err_cnt <= err_cnt + ECW'(1);
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Directed bench for bk_pipe_adder: a W=32/PIPE=1 instance and a W=4/PIPE=2/ECW=2 instance.
// Checks reset, add/sub results, latency, stalls, flush on reset, checker and counter.
// Faults on the tree carry-out are injected with force/release.
module tb_bk_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        m_in_valid, m_in_ready, m_cin, m_sub;
  logic        m_out_valid, m_out_ready, m_cout, m_ovf, m_chk_err, m_err_clr;
  logic [31:0] m_ina, m_inb, m_sum;
  logic [15:0] m_err_cnt;

  logic        s_in_valid, s_in_ready, s_cin, s_sub;
  logic        s_out_valid, s_out_ready, s_cout, s_ovf, s_chk_err, s_err_clr;
  logic [3:0]  s_ina, s_inb, s_sum;
  logic [1:0]  s_err_cnt;

  int errors = 0;
  int checks = 0;
  int nsent;
  int nrecv;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  bk_pipe_adder #(.W(32), .PIPE(1), .ECW(16)) u_m (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .ina(m_ina), .inb(m_inb), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .cout(m_cout), .ovf(m_ovf),
    .chk_err(m_chk_err), .err_cnt(m_err_cnt), .err_clr(m_err_clr)
  );

  bk_pipe_adder #(.W(4), .PIPE(2), .ECW(2)) u_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ina(s_ina), .inb(s_inb), .cin(s_cin), .sub(s_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf),
    .chk_err(s_chk_err), .err_cnt(s_err_cnt), .err_clr(s_err_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_in_valid = 0; m_ina = '0; m_inb = '0; m_cin = 0; m_sub = 0; m_out_ready = 1; m_err_clr = 0;
    s_in_valid = 0; s_ina = '0; s_inb = '0; s_cin = 0; s_sub = 0; s_out_ready = 1; s_err_clr = 0;
    tick;
    tick;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_sum", m_sum, 0);
    chk("rst_cout", m_cout, 0);
    chk("rst_ovf", m_ovf, 0);
    chk("rst_chk_err", m_chk_err, 0);
    chk("rst_err_cnt", m_err_cnt, 0);
    chk("rst_in_ready", m_in_ready, 1);
    chk("rst_s_out_valid", s_out_valid, 0);
    chk("rst_s_in_ready", s_in_ready, 1);

    // Single add 0xFFFFFFFF + 1, latency 3
    m_in_valid = 1; m_ina = 32'hFFFF_FFFF; m_inb = 32'h1; m_cin = 0; m_sub = 0;
    tick;
    m_in_valid = 0;
    chk("add_lat1_valid", m_out_valid, 0);
    tick;
    chk("add_lat2_valid", m_out_valid, 0);
    tick;
    chk("add_valid", m_out_valid, 1);
    chk("add_sum", m_sum, 32'h0);
    chk("add_cout", m_cout, 1);
    chk("add_ovf", m_ovf, 0);
    chk("add_chk_err", m_chk_err, 0);
    tick;

    // Subtract: 5-7 then 0x80000000-1, cin ignored in subtract mode
    m_in_valid = 1; m_sub = 1; m_cin = 1; m_ina = 32'd5; m_inb = 32'd7;
    tick;
    m_ina = 32'h8000_0000; m_inb = 32'h1;
    tick;
    m_in_valid = 0; m_sub = 0; m_cin = 0;
    tick;
    chk("sub1_valid", m_out_valid, 1);
    chk("sub1_sum", m_sum, 32'hFFFF_FFFE);
    chk("sub1_cout", m_cout, 0);
    chk("sub1_ovf", m_ovf, 0);
    tick;
    chk("sub2_valid", m_out_valid, 1);
    chk("sub2_sum", m_sum, 32'h7FFF_FFFF);
    chk("sub2_cout", m_cout, 1);
    chk("sub2_ovf", m_ovf, 1);
    tick;
    chk("bubble_valid", m_out_valid, 0);
    chk("bubble_hold_sum", m_sum, 32'h7FFF_FFFF);

    // Back-to-back stream of 8 with a 3-cycle output stall
    nsent = 0;
    nrecv = 0;
    for (int cyc = 0; cyc < 40 && nrecv < 8; cyc++) begin
      m_in_valid  = (nsent < 8);
      m_ina       = 32'(nsent);
      m_inb       = 32'(nsent) << 4;
      m_cin       = nsent[0];
      m_out_ready = !(cyc >= 6 && cyc < 9);
      #1;
      if (cyc >= 6 && cyc < 9) begin
        chk("bp_in_ready_low", m_in_ready, 0);
        chk("bp_hold_valid", m_out_valid, 1);
        if (exp_q.size() != 0) chk("bp_hold_sum", m_sum, exp_q[0]);
      end
      if (m_out_valid && m_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_spurious_beat", m_out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bp_sum", m_sum, e);
        end
        nrecv++;
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(32'(nsent) + (32'(nsent) << 4) + 32'(nsent & 1));
        nsent++;
      end
      tick;
    end
    chk("bp_count", nrecv, 8);
    m_in_valid = 0; m_out_ready = 1; m_cin = 0;
    tick;
    tick;
    tick;

    // Reset while three beats are in flight: none may emerge
    m_in_valid = 1; m_ina = 32'd10; m_inb = 32'd0;
    tick;
    m_ina = 32'd11;
    tick;
    m_ina = 32'd12; rst = 1;
    tick;
    rst = 0; m_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("rst_flush_valid", m_out_valid, 0);
      tick;
    end
    chk("rst_flush_err_cnt", m_err_cnt, 0);
    chk("rst_flush_sum", m_sum, 0);

    // Faulted tree carry on 3 beats (1+1 has no real carry-out)
    force u_m.bk_cout = 1'b1;
    m_in_valid = 1; m_ina = 32'd1; m_inb = 32'd1; m_cin = 0; m_sub = 0;
    tick;
    tick;
    tick;
    m_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("flt_valid", m_out_valid, 1);
      chk("flt_chk_err", m_chk_err, 1);
      chk("flt_sum", m_sum, 32'd2);
      chk("flt_cnt_prog", m_err_cnt, i);
      tick;
    end
    chk("flt_valid_end", m_out_valid, 0);
    chk("flt_cnt3", m_err_cnt, 3);

    // Fourth error coincides with err_clr: clear wins
    m_in_valid = 1;
    tick;
    m_in_valid = 0;
    tick;
    tick;
    chk("clr_beat_valid", m_out_valid, 1);
    chk("clr_beat_chk_err", m_chk_err, 1);
    m_err_clr = 1;
    tick;
    m_err_clr = 0;
    chk("clr_wins", m_err_cnt, 0);
    release u_m.bk_cout;

    // Healthy beat after the fault is removed
    m_in_valid = 1; m_ina = 32'd1; m_inb = 32'd1;
    tick;
    m_in_valid = 0;
    tick;
    tick;
    chk("clean_valid", m_out_valid, 1);
    chk("clean_chk_err", m_chk_err, 0);
    chk("clean_cout", m_cout, 0);
    chk("clean_sum", m_sum, 32'd2);
    tick;
    chk("clean_err_cnt", m_err_cnt, 0);

    // W=4, PIPE=2: latency 4 and signed overflow in both modes
    s_in_valid = 1; s_sub = 1; s_ina = 4'd3; s_inb = 4'd5;
    tick;
    s_sub = 0; s_ina = 4'd7; s_inb = 4'd1; s_cin = 0;
    tick;
    s_sub = 1; s_ina = 4'd8; s_inb = 4'd1;
    tick;
    s_in_valid = 0; s_sub = 0;
    chk("s_lat3_valid", s_out_valid, 0);
    tick;
    chk("s_sub1_valid", s_out_valid, 1);
    chk("s_sub1_sum", s_sum, 4'hE);
    chk("s_sub1_cout", s_cout, 0);
    chk("s_sub1_ovf", s_ovf, 0);
    tick;
    chk("s_add_sum", s_sum, 4'h8);
    chk("s_add_cout", s_cout, 0);
    chk("s_add_ovf", s_ovf, 1);
    tick;
    chk("s_sub2_sum", s_sum, 4'h7);
    chk("s_sub2_cout", s_cout, 1);
    chk("s_sub2_ovf", s_ovf, 1);
    chk("s_sub2_chk_err", s_chk_err, 0);
    tick;

    // ECW=2 counter saturates at 3 after 5 faulted beats
    force u_s.bk_cout = 1'b1;
    s_in_valid = 1; s_ina = 4'd1; s_inb = 4'd1; s_cin = 0;
    repeat (5) tick;
    s_in_valid = 0;
    repeat (6) tick;
    chk("s_sat_cnt", s_err_cnt, 3);
    release u_s.bk_cout;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
